// File: rtl/queue_pkg.sv
// Shared definitions for the parametrised queue: ordering-mode selector.
package queue_pkg;

  typedef enum logic {
    MODE_FIFO = 1'b0,
    MODE_LIFO = 1'b1
  } queue_mode_e;

endpackage

// File: rtl/queue_mem.sv
// Queue storage: WIDTH x DEPTH register array, one synchronous write port
// and one combinational read port.
module queue_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; occupancy lives in the control logic, so
  // stale contents are never observable and the array can map to plain flops.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_queue.sv
// Bounded FIFO/LIFO buffer with occupancy flags, dequeue-valid strobe and
// sticky overflow/underflow errors.
module param_queue
  import queue_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int          DEPTH = 8,
  parameter queue_mode_e MODE  = MODE_FIFO,
  parameter int          LW    = $clog2(DEPTH + 1)
) (
  input  logic             clock_10,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enq_in,
  input  logic             deq_in,
  input  logic             clear_err_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [LW-1:0]    len_out,
  output logic             full_out,
  output logic             empty_out,
  output logic             overflow_out,
  output logic             underflow_out
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LEN = LW'(DEPTH);

  logic [LW-1:0]    len_q, len_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             empty, full;
  logic             push_ok, pop_ok, ovf_evt, unf_evt;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] rdata;

  assign empty = (len_q == '0);
  assign full  = (len_q == FULL_LEN);

  // A push into a full queue only succeeds when a pop frees a slot that cycle.
  assign push_ok = enq_in && (!full || deq_in);
  assign pop_ok  = deq_in && !empty;
  assign ovf_evt = enq_in && full && !deq_in;
  assign unf_evt = deq_in && empty;

  queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clock_10),
    .we    (push_ok),
    .waddr (waddr),
    .wdata (data_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  if (MODE == MODE_FIFO) begin : g_fifo
    localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;

    // Explicit wrap compare so non-power-of-two depths cycle correctly.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
        wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
      end
    end

    always_ff @(posedge clock_10) begin
      if (!reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    assign waddr = wr_ptr_q;
    assign raddr = rd_ptr_q;
  end else begin : g_lifo
    // Top of stack is len; a simultaneous push/pop overwrites the popped slot.
    assign raddr = AW'(len_q - 1'b1);
    assign waddr = pop_ok ? AW'(len_q - 1'b1) : AW'(len_q);
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    len_d   = len_q;
    data_d  = data_q;
    valid_d = pop_ok;
    ovf_d   = ovf_evt || (ovf_q && !clear_err_in);
    unf_d   = unf_evt || (unf_q && !clear_err_in);
    if (push_ok && !pop_ok) begin
      len_d = len_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      len_d = len_q - 1'b1;
    end
    if (pop_ok) begin
      data_d = rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_10) begin
    if (!reset) begin
      len_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      len_q   <= len_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign len_out       = len_q;
  assign full_out      = full;
  assign empty_out     = empty;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;

endmodule

// File: tb/tb_param_queue.sv
// Self-checking bench for param_queue: FIFO depth 8, LIFO depth 8 and FIFO
// depth 5 instances share stimulus; a word queue holds expected outputs.
`timescale 1us/1ns
module tb_param_queue;
  import queue_pkg::*;

  logic       clock_10 = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       enq_in, deq_in, clear_err_in;

  logic [7:0] f_data, l_data, o_data;
  logic       f_valid, l_valid, o_valid;
  logic [3:0] f_len, l_len;
  logic [2:0] o_len;
  logic       f_full, l_full, o_full;
  logic       f_empty, l_empty, o_empty;
  logic       f_ovf, l_ovf, o_ovf;
  logic       f_unf, l_unf, o_unf;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] sb[$];

  always #50 clock_10 = ~clock_10;

  param_queue #(.WIDTH(8), .DEPTH(8), .MODE(MODE_FIFO)) u_fifo (
    .clock_10(clock_10), .reset(reset), .data_in(data_in), .enq_in(enq_in),
    .deq_in(deq_in), .clear_err_in(clear_err_in), .data_out(f_data),
    .valid_out(f_valid), .len_out(f_len), .full_out(f_full),
    .empty_out(f_empty), .overflow_out(f_ovf), .underflow_out(f_unf));

  param_queue #(.WIDTH(8), .DEPTH(8), .MODE(MODE_LIFO)) u_lifo (
    .clock_10(clock_10), .reset(reset), .data_in(data_in), .enq_in(enq_in),
    .deq_in(deq_in), .clear_err_in(clear_err_in), .data_out(l_data),
    .valid_out(l_valid), .len_out(l_len), .full_out(l_full),
    .empty_out(l_empty), .overflow_out(l_ovf), .underflow_out(l_unf));

  param_queue #(.WIDTH(8), .DEPTH(5), .MODE(MODE_FIFO)) u_odd (
    .clock_10(clock_10), .reset(reset), .data_in(data_in), .enq_in(enq_in),
    .deq_in(deq_in), .clear_err_in(clear_err_in), .data_out(o_data),
    .valid_out(o_valid), .len_out(o_len), .full_out(o_full),
    .empty_out(o_empty), .overflow_out(o_ovf), .underflow_out(o_unf));

  // Drive one edge worth of requests; outputs are sampled 1us after the edge.
  task automatic cycle(input logic e, input logic d, input logic [7:0] din,
                       input logic clr);
    enq_in = e; deq_in = d; data_in = din; clear_err_in = clr;
    @(posedge clock_10);
    #1;
    enq_in = 1'b0; deq_in = 1'b0; clear_err_in = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    sb.delete();
  endtask

  task automatic fill_fifo8();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, 8'(i * 17), 1'b0);
      sb.push_back(8'(i * 17));
    end
  endtask

  task automatic drain_fifo8(input int n, output logic [7:0] last);
    last = 8'h00;
    for (int i = 0; i < n; i++) begin
      logic [7:0] exp;
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      exp = sb.pop_front();
      tests_run++;
      if (f_valid !== 1'b1 || f_data !== exp) begin
        tests_failed++;
        $display("FAIL fifo_drain[%0d] got valid=%b data=%h want valid=1 data=%h", i, f_valid, f_data, exp);
      end
      last = f_data;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enq_in = 1'b1; deq_in = 1'b0; clear_err_in = 1'b0; data_in = 8'h5A;
    @(posedge clock_10); #1;
    @(posedge clock_10); #1;
    enq_in = 1'b0;
    reset = 1'b1;
    tests_run++;
    if ({f_len, f_empty, f_full, f_valid, f_data, f_ovf, f_unf} !== {4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state got len=%0d empty=%b full=%b valid=%b data=%h ovf=%b unf=%b want 0 1 0 0 00 0 0",
               f_len, f_empty, f_full, f_valid, f_data, f_ovf, f_unf);
    end
  endtask

  task automatic test_fifo_order();
    logic [7:0] last;
    apply_reset();
    fill_fifo8();
    tests_run++;
    if (f_len !== 4'd8 || f_full !== 1'b1 || f_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL fifo_fill got len=%0d full=%b empty=%b want 8 1 0", f_len, f_full, f_empty);
    end
    drain_fifo8(8, last);
    tests_run++;
    if (f_len !== 4'd0 || f_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL fifo_drained got len=%0d empty=%b want 0 1", f_len, f_empty);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if (f_valid !== 1'b0 || f_data !== 8'h88) begin
      tests_failed++;
      $display("FAIL fifo_hold got valid=%b data=%h want 0 88", f_valid, f_data);
    end
  endtask

  task automatic test_lifo_order();
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
      sb.push_back(8'(8'hA0 + i));
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] exp;
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      exp = sb.pop_back();
      tests_run++;
      if (l_valid !== 1'b1 || l_data !== exp) begin
        tests_failed++;
        $display("FAIL lifo_pop[%0d] got valid=%b data=%h want 1 %h", i, l_valid, l_data, exp);
      end
    end
  endtask

  task automatic test_lifo_replace();
    logic [7:0] exp;
    apply_reset();
    cycle(1'b1, 1'b0, 8'hC1, 1'b0); sb.push_back(8'hC1);
    cycle(1'b1, 1'b0, 8'hC2, 1'b0); sb.push_back(8'hC2);
    cycle(1'b1, 1'b1, 8'hB7, 1'b0);
    exp = sb.pop_back(); sb.push_back(8'hB7);
    tests_run++;
    if (l_data !== exp || l_valid !== 1'b1 || l_len !== 4'd2) begin
      tests_failed++;
      $display("FAIL lifo_both got data=%h valid=%b len=%0d want %h 1 2", l_data, l_valid, l_len, exp);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      exp = sb.pop_back();
      tests_run++;
      if (l_data !== exp) begin
        tests_failed++;
        $display("FAIL lifo_after_both[%0d] got %h want %h", i, l_data, exp);
      end
    end
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] last;
    apply_reset();
    fill_fifo8();
    cycle(1'b1, 1'b0, 8'h99, 1'b0);
    tests_run++;
    if (f_len !== 4'd8 || f_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow got len=%0d ovf=%b want 8 1", f_len, f_ovf);
    end
    drain_fifo8(8, last);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    tests_run++;
    if (f_unf !== 1'b1 || f_valid !== 1'b0 || f_data !== last || f_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow got unf=%b valid=%b data=%h ovf=%b want 1 0 %h 1", f_unf, f_valid, f_data, f_ovf, last);
    end
  endtask

  task automatic test_full_simultaneous();
    logic [7:0] exp, last;
    apply_reset();
    fill_fifo8();
    cycle(1'b1, 1'b1, 8'hEE, 1'b0);
    exp = sb.pop_front(); sb.push_back(8'hEE);
    tests_run++;
    if (f_data !== exp || f_valid !== 1'b1 || f_len !== 4'd8 || f_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_both got data=%h valid=%b len=%0d ovf=%b want %h 1 8 0", f_data, f_valid, f_len, f_ovf, exp);
    end
    drain_fifo8(8, last);
    tests_run++;
    if (last !== 8'hEE) begin
      tests_failed++;
      $display("FAIL full_both_last got %h want ee", last);
    end
  endtask

  task automatic test_both_empty();
    apply_reset();
    cycle(1'b1, 1'b1, 8'h5A, 1'b0);
    tests_run++;
    if (f_len !== 4'd1 || f_valid !== 1'b0 || f_unf !== 1'b1 || f_data !== 8'h00 ||
        l_len !== 4'd1 || l_valid !== 1'b0 || l_unf !== 1'b1) begin
      tests_failed++;
      $display("FAIL both_empty got flen=%0d fvalid=%b funf=%b fdata=%h llen=%0d lvalid=%b lunf=%b want 1 0 1 00 1 0 1",
               f_len, f_valid, f_unf, f_data, l_len, l_valid, l_unf);
    end
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    tests_run++;
    if (f_data !== 8'h5A || l_data !== 8'h5A) begin
      tests_failed++;
      $display("FAIL both_empty_pop got fifo=%h lifo=%h want 5a 5a", f_data, l_data);
    end
  endtask

  task automatic test_wrap_odd();
    logic [7:0] v = 8'h30;
    logic [7:0] exp;
    int errs = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, v, 1'b0); sb.push_back(v); v++;
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, v, 1'b0); sb.push_back(v); v++;
      tests_run++;
      if (o_full !== 1'b1 || o_len !== 3'd5) begin
        tests_failed++;
        $display("FAIL odd_full[%0d] got full=%b len=%0d want 1 5", i, o_full, o_len);
      end
      cycle(1'b1, 1'b1, v, 1'b0); exp = sb.pop_front(); sb.push_back(v); v++;
      if (o_data !== exp || o_valid !== 1'b1 || o_len !== 3'd5) errs++;
      cycle(1'b0, 1'b1, 8'h00, 1'b0); exp = sb.pop_front();
      if (o_data !== exp || o_valid !== 1'b1) errs++;
    end
    while (sb.size() > 0) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0); exp = sb.pop_front();
      if (o_data !== exp) errs++;
    end
    tests_run++;
    if (errs != 0 || o_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL odd_sequence got %0d word errors empty=%b want 0 errors empty=1", errs, o_empty);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    tests_run++;
    if (f_len !== 4'd4 || f_unf !== 1'b1 || f_data !== 8'h51) begin
      tests_failed++;
      $display("FAIL mid_pre got len=%0d unf=%b data=%h want 4 1 51", f_len, f_unf, f_data);
    end
    reset = 1'b0;
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    reset = 1'b1;
    tests_run++;
    if ({f_len, f_empty, f_ovf, f_unf, f_valid, f_data} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL mid_reset got len=%0d empty=%b ovf=%b unf=%b valid=%b data=%h want 0 1 0 0 0 00",
               f_len, f_empty, f_ovf, f_unf, f_valid, f_data);
    end
    cycle(1'b1, 1'b0, 8'h42, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    tests_run++;
    if (f_data !== 8'h42 || f_valid !== 1'b1 || f_len !== 4'd0) begin
      tests_failed++;
      $display("FAIL mid_release got data=%h valid=%b len=%0d want 42 1 0", f_data, f_valid, f_len);
    end
  endtask

  task automatic test_clear_err();
    apply_reset();
    fill_fifo8();
    cycle(1'b1, 1'b0, 8'h99, 1'b0);
    cycle(1'b1, 1'b0, 8'h9A, 1'b1);
    tests_run++;
    if (f_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_vs_event got ovf=%b want 1", f_ovf);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    tests_run++;
    if (f_ovf !== 1'b0 || f_len !== 4'd8) begin
      tests_failed++;
      $display("FAIL clear_alone got ovf=%b len=%0d want 0 8", f_ovf, f_len);
    end
  endtask

  initial begin
    enq_in = 1'b0; deq_in = 1'b0; clear_err_in = 1'b0; data_in = 8'h00; reset = 1'b0;
    test_reset();
    test_fifo_order();
    test_lifo_order();
    test_lifo_replace();
    test_overflow_underflow();
    test_full_simultaneous();
    test_both_empty();
    test_wrap_odd();
    test_reset_midstream();
    test_clear_err();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/param_queue.md
# param_queue

Parametrised successor to the fixed 8×8 queue: a bounded buffer with configurable data width, depth and ordering mode (FIFO or LIFO). It adds full/empty flags, a dequeue-valid strobe, defined simultaneous enqueue/dequeue behaviour, and sticky overflow/underflow error flags. It runs in the 10 kHz clock domain and buffers words between the deserialiser front end and its consumer.

## Interface
- WIDTH, 8: data word width in bits, ≥1
- DEPTH, 8: number of storage slots, ≥2; the design must also work for non-powers of two
- MODE, MODE_FIFO: ordering, MODE_FIFO or MODE_LIFO (queue_pkg::queue_mode_e)
- LW, $clog2(DEPTH+1): width of len_out (derived; do not override)

- clock_10  in  1  10 kHz system clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset; sampled on clock_10 rising edge
- data_in  in  WIDTH  word to enqueue
- enq_in  in  1  enqueue request, sampled each edge
- deq_in  in  1  dequeue request, sampled each edge
- clear_err_in  in  1  synchronous clear of overflow_out/underflow_out
- data_out  out  WIDTH  last dequeued word; holds until the next successful dequeue
- valid_out  out  1  one-cycle strobe: data_out was updated this cycle
- len_out  out  LW  number of occupied slots, 0..DEPTH
- full_out  out  1  len_out == DEPTH
- empty_out  out  1  len_out == 0
- overflow_out  out  1  sticky: an enqueue was dropped
- underflow_out  out  1  sticky: a dequeue hit an empty queue

## Operation
- Reset (reset==0 at an edge): len 0, pointers 0, data_out 0, valid_out 0, overflow/underflow 0. This gives full_out 0 and empty_out 1. Storage contents are don't-care. Reset overrides every other input in that cycle.
- All decisions use the registered len at the edge, not the post-update value.
- FIFO: circular buffer with wr_ptr and rd_ptr. Each pointer wraps from DEPTH-1 to 0 with an explicit compare, not modulo-2^n.
- LIFO: a single top index equal to len. Push writes slot[len]; pop reads slot[len-1].
- Enqueue only, len<DEPTH: store data_in, len+1.
- Enqueue only, len==DEPTH: word dropped, len unchanged, overflow_out←1.
- Dequeue only, len>0: data_out←oldest word (FIFO) or newest word (LIFO), valid_out←1, len−1.
- Dequeue only, len==0: data_out unchanged, valid_out 0, underflow_out←1.
- Both, 0<len≤DEPTH:
  - FIFO: pop oldest and push data_in in the same cycle; len unchanged. This holds when full, because the freed slot absorbs the push.
  - LIFO: data_out←current top, slot[len-1]←data_in; len unchanged.
- Both, len==0 (both modes): enqueue accepted (len 0→1), dequeue rejected, underflow_out←1. There is no pass-through of data_in.
- clear_err_in==1 zeroes both error flags. If an error event occurs in the same cycle, the event wins and the flag ends at 1.
- data_out is never driven from storage combinationally. It changes only on a successful dequeue.

## Timing
- Dequeue latency is 1 cycle: deq_in high at edge N (with len>0) puts the word on data_out and asserts valid_out after edge N. valid_out drops after edge N+1 unless another dequeue succeeds.
- len_out, full_out and empty_out reflect edge N's operation after edge N. full_out and empty_out are decoded combinationally from the len register.
- Error flags set after the offending edge.
- Back-to-back dequeues give one word per cycle with valid_out held high.
- Reset asserted mid-stream discards all contents. The first enqueue after release is accepted at the first edge with reset==1.

## Structure
- Package queue_pkg holds the typedef enum queue_mode_e {MODE_FIFO, MODE_LIFO}.
- Sub-module queue_mem holds the storage:
  - WIDTH×DEPTH register array
  - one synchronous write port (we, waddr, wdata)
  - one combinational read port (raddr → rdata)
  - no reset on the array
- The top level holds pointer/len control, the MODE-dependent address select (generate on MODE), the output register and the flags.

## Test plan
- FIFO, DEPTH=8, WIDTH=8: enqueue 0x11..0x88, then 8 dequeues → data_out 0x11,0x22,…,0x88 on consecutive cycles, valid_out high 8 cycles, len 8→0, empty_out 1.
- LIFO: enqueue 0xA1,0xA2,0xA3, then 3 dequeues → data_out 0xA3,0xA2,0xA1.
- Full and empty boundaries:
  - FIFO, fill 8, enqueue 0x99 → len stays 8, overflow_out 1, and a later drain never returns 0x99.
  - On empty, dequeue → underflow_out 1, valid_out 0, data_out unchanged.
- FIFO full, enq+deq with data_in=0xEE → data_out=oldest, len stays 8. Drain the remaining 8 → 0xEE is the last word out.
- Wrap-around and odd depth: FIFO with DEPTH=5, interleave 20 enqueue/dequeue pairs of incrementing data → output sequence equals input sequence.
- Pull reset low at len=4 → after the edge len_out 0, empty_out 1, error flags 0. Assert clear_err_in together with an overflow event → overflow_out stays 1.
